seq_restoring_divider: RTL and testbench

- Sequential unsigned restoring divider: dividend / divisor.
- Consumes one trial subtraction per clock: the partial remainder minus the divisor, using difference plus borrow-out.
- Sits directly downstream of the team's ripple subtractor datapath. The borrow-out of each trial subtraction decides quotient bit and restore.
- One result per WIDTH cycles, with a start/done handshake toward the controlling logic.

---
 rtl/seq_restoring_divider.sv | 104 ++++++++++
 tb/tb_seq_restoring_divider.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// start/done handshake, divide-by-zero reported with the result.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   r_work;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // r_work's top bit is always zero after a step; the cast drops it when shifting.
  always_comb begin
    shifted         = (WIDTH+1)'({r_work, q_work[WIDTH-1]});
    {borrow, trial} = {1'b0, shifted} - {2'b00, d};
    r_next          = borrow ? shifted : trial;
    q_next          = {q_work[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r_work      <= '0;
      q_work      <= '0;
      d           <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              q_work <= dividend;
              d      <= divisor;
              r_work <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r_work <= r_next;
          q_work <= q_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=8) with hand-computed results.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int assertions;
  int failures;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start and wait (bounded) until done is seen at a falling edge.
  // n = falling edges waited after the accept edge (done at accept+n+1 edges).
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output int n, output int bc);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n  = 0;
    bc = 0;
    while (done !== 1'b1 && n < 30) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    assertions++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b q=%0d r=%0d dz=%b, required all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int n, bc;
    run_div(8'd200, 8'd7, n, bc);
    assertions++;
    if (n !== 8) begin
      failures++;
      $display("FAIL basic_latency: edges=%0d required 9", n + 1);
    end
    assertions++;
    if (bc !== 8) begin
      failures++;
      $display("FAIL basic_busy_cycles: %0d required 8", bc);
    end
    assertions++;
    if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: q=%0d r=%0d dz=%b required q=28 r=4 dz=0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    assertions++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4) begin
      failures++;
      $display("FAIL basic_hold: done=%b busy=%b q=%0d r=%0d required done=0 busy=0 q=28 r=4",
               done, busy, quotient, remainder);
    end
  endtask

  task automatic test_values();
    logic [7:0] va [5] = '{8'd255, 8'd5, 8'd255, 8'd100, 8'd0};
    logic [7:0] vb [5] = '{8'd1,   8'd9, 8'd255, 8'd3,   8'd5};
    logic [7:0] eq [5] = '{8'd255, 8'd0, 8'd1,   8'd33,  8'd0};
    logic [7:0] er [5] = '{8'd0,   8'd5, 8'd0,   8'd1,   8'd0};
    int n, bc;
    for (int i = 0; i < 5; i++) begin
      run_div(va[i], vb[i], n, bc);
      assertions++;
      if (n !== 8 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL values_%0d_%0d: edges=%0d q=%0d r=%0d dz=%b required edges=9 q=%0d r=%0d dz=0",
                 va[i], vb[i], n + 1, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int n, bc;
    run_div(8'd77, 8'd0, n, bc);
    assertions++;
    if (n !== 0 || bc !== 0) begin
      failures++;
      $display("FAIL dz_latency: edges=%0d busy_cycles=%0d required edges=1 busy_cycles=0", n + 1, bc);
    end
    assertions++;
    if (quotient !== 8'hFF || remainder !== 8'd77 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_result: q=%0h r=%0d dz=%b required q=ff r=77 dz=1",
               quotient, remainder, div_by_zero);
    end
    run_div(8'd200, 8'd7, n, bc);
    assertions++;
    if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL dz_clear: q=%0d r=%0d dz=%b required q=28 r=4 dz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        pulses++;
        assertions++;
        if (quotient !== 8'd28 || remainder !== 8'd4) begin
          failures++;
          $display("FAIL ignore_result: q=%0d r=%0d required q=28 r=4", quotient, remainder);
        end
      end
      @(negedge clk);
    end
    assertions++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL ignore_pulses: %0d done pulses required 1", pulses);
    end
  endtask

  task automatic test_reset_abort();
    int pulses, n, bc;
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    assertions++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      failures++;
      $display("FAIL abort_reset: busy=%b done=%b q=%0d r=%0d dz=%b required all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    assertions++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d active cycles required 0", pulses);
    end
    run_div(8'd100, 8'd3, n, bc);
    assertions++;
    if (n !== 8 || quotient !== 8'd33 || remainder !== 8'd1) begin
      failures++;
      $display("FAIL abort_fresh: edges=%0d q=%0d r=%0d required edges=9 q=33 r=1",
               n + 1, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int n, bc, held_bad;
    run_div(8'd200, 8'd7, n, bc);
    // Still in the DONE cycle: request the next division right away.
    dividend = 8'd9;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    assertions++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    held_bad = 0;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      if (quotient !== 8'd28 || remainder !== 8'd4) held_bad++;
      @(negedge clk);
      n++;
    end
    assertions++;
    if (held_bad !== 0) begin
      failures++;
      $display("FAIL b2b_hold: %0d cycles with changed results required 0", held_bad);
    end
    assertions++;
    if (n !== 8 || quotient !== 8'd4 || remainder !== 8'd1) begin
      failures++;
      $display("FAIL b2b_result: edges=%0d q=%0d r=%0d required edges=9 q=4 r=1",
               n + 1, quotient, remainder);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, eq, er;
    logic       ez;
    int n, bc, en;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin
        eq = 8'hFF; er = a; ez = 1'b1; en = 0;
      end else begin
        eq = a / b; er = a % b; ez = 1'b0; en = 8;
      end
      run_div(a, b, n, bc);
      assertions++;
      if (n !== en || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        failures++;
        $display("FAIL random_%0d_%0d: edges=%0d q=%0d r=%0d dz=%b required edges=%0d q=%0d r=%0d dz=%b",
                 a, b, n + 1, quotient, remainder, div_by_zero, en + 1, eq, er, ez);
      end
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    test_reset();
    test_basic();
    test_values();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
